dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Sequencing controller for the 2-way write-through data cache. It accepts one load/store at a time from the LSU and drives the cache's address, write data and enables. Load misses are refilled from backing memory using the cache's write-allocate path. Every store is written through to memory. It keeps saturating hit/miss counters for low-power profiling.

Parameters:
ADDR_WIDTH, 12, byte address width (matches cache)
DATA_WIDTH, 64, data word width
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  access request; sampled only in IDLE
cpu_we  in  1  1=store, 0=load; sampled with cpu_req
cpu_addr  in  ADDR_WIDTH  access address
cpu_wdata  in  DATA_WIDTH  store data
cpu_rdata  out  DATA_WIDTH  load result; valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_busy  out  1  high whenever state != IDLE
cache_addr  out  ADDR_WIDTH  to cache address
cache_wdata  out  DATA_WIDTH  to cache write_data
cache_we  out  1  to cache write_enable
cache_re  out  1  to cache read_enable
cache_hit  in  1  from cache (combinational)
cache_rdata  in  DATA_WIDTH  from cache read_data
mem_req  out  1  memory request
mem_we  out  1  memory write qualifier
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion; for reads, mem_rdata is valid in the same cycle
mem_rdata  in  DATA_WIDTH  memory read data
perf_clr  in  1  synchronous clear of both counters
hit_cnt  out  CNT_WIDTH  saturating hit count
miss_cnt  out  CNT_WIDTH  saturating miss count

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Latched addr/we/wdata, refill buffer, cpu_rdata, hit_cnt and miss_cnt all go to 0. All strobes are 0 (cpu_ready, cache_we, cache_re, mem_req). A reset mid-operation abandons the transaction immediately: mem_req drops and no cpu_ready is issued.
- States: IDLE, LOOKUP, MEM_RD, REFILL, MEM_WR, RESP.
- IDLE: when cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata, then go to LOOKUP. cpu_req in any other state is ignored; the LSU must hold it until cpu_busy falls.
- cache_addr and mem_addr always come from the latched address. cache_we, cache_re, mem_req and mem_we are decoded from state only.
- LOOKUP (exactly 1 cycle):
  - Load: cache_re=1. On hit, register cpu_rdata<=cache_rdata, increment hit_cnt, go to RESP. On miss, increment miss_cnt, go to MEM_RD.
  - Store: cache_we=1 with cache_wdata=latched data. The cache updates on hit or allocates on miss. Increment hit_cnt if cache_hit, else miss_cnt. Go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, held stable until mem_ack. On mem_ack, capture mem_rdata into the refill buffer and go to REFILL. There is no abort or timeout.
- REFILL (1 cycle): cache_we=1 with cache_wdata=refill buffer, which allocates into the LRU way. Register cpu_rdata<=refill buffer, go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched data, held until mem_ack, then go to RESP. mem_rdata is ignored.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE.
  - cpu_rdata holds its value until the next load completes.
  - For a store, cpu_rdata is unchanged.
- Latency, counting the accept edge as cycle 0:
  - Load hit: cpu_ready high in cycle 2.
  - Load miss with mem_ack in the Nth MEM_RD cycle (N>=1): cpu_ready in cycle 3+N.
  - Store with ack in the Nth MEM_WR cycle: cpu_ready in cycle 2+N.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- A back-to-back request is accepted in the cycle after RESP, so there is a minimum 1 idle cycle between accesses.
- Counters:
  - Increment by 1 only in LOOKUP and saturate at all-ones.
  - perf_clr has priority over a simultaneous increment, giving 0 next cycle.
- Power: cache_re and cache_we are asserted only in the states above, so the cache sees no enables in IDLE.

Decomposition:
- dcache_ctrl_pkg: state enum (IDLE..RESP, 3-bit encoding) and default width constants.
- One sub-module: sat_counter (parameter CNT_WIDTH; inputs inc and clr, clr wins; saturating). It is instantiated twice, for hits and misses.

Test Plan:
- Load miss then load hit:
  - Stimulus: load 0x123, no prior fill, mem_ack on the 2nd MEM_RD cycle with mem_rdata=0xDEAD_BEEF_0000_0001.
  - Response: cache_we pulses in REFILL; cpu_ready in cycle 5 with that data; miss_cnt=1.
  - Then reload 0x123: cpu_ready in cycle 2 with the same data; hit_cnt=1; mem_req stays 0.
- Store write-through:
  - Stimulus: store 0x040 with data 0x55AA, mem_ack after 3 cycles.
  - Response: cache_we=1 in LOOKUP; mem_req=1, mem_we=1, mem_wdata=0x55AA for 3 cycles; cpu_ready in cycle 5.
  - Then load 0x040: hit returning 0x55AA.
- Request while busy:
  - Stimulus: assert a second cpu_req with a different address during MEM_RD.
  - Response: ignored, no latch change; accepted only once back in IDLE.
- Counter saturation and clear:
  - Stimulus: force hit_cnt to 0xFFFF, then issue a hit; next, assert perf_clr together with a LOOKUP hit.
  - Response: hit_cnt stays 0xFFFF after the first hit; it becomes 0 after the clear.
- Reset mid-refill:
  - Stimulus: drop rst_n while in MEM_RD.
  - Response: mem_req falls asynchronously; no cpu_ready; counters=0; cpu_busy=0; next request behaves normally.
- Spurious ack:
  - Stimulus: pulse mem_ack in IDLE and in LOOKUP.
  - Response: no state change, no cpu_ready.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and default widths for the write-through data cache controller.
package dcache_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    REFILL = 3'd3,
    MEM_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/dcache_ctrl.sv
// Sequences one LSU load/store at a time through a write-through, write-allocate
// cache: lookup, memory refill on load miss, memory write-through on every store.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_we,
  output logic                  cache_re,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  perf_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_refill;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_hit_inc;
  logic                  w_miss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_next = LOOKUP;
      LOOKUP:  w_next = r_we ? MEM_WR : (cache_hit ? RESP : MEM_RD);
      MEM_RD:  if (mem_ack) w_next = REFILL;
      REFILL:  w_next = RESP;
      MEM_WR:  if (mem_ack) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes depend on state alone so the cache sees no enables while idle.
  always_comb begin
    cpu_ready   = 1'b0;
    cache_we    = 1'b0;
    cache_re    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    cache_wdata = r_wdata;
    case (r_state)
      LOOKUP: begin
        cache_re = ~r_we;
        cache_we = r_we;
      end
      MEM_RD: mem_req = 1'b1;
      REFILL: begin
        cache_we    = 1'b1;
        cache_wdata = r_refill;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      RESP:    cpu_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_refill <= '0;
      r_rdata  <= '0;
    end else begin
      if ((r_state == IDLE) && cpu_req) begin
        r_addr  <= cpu_addr;
        r_we    <= cpu_we;
        r_wdata <= cpu_wdata;
      end
      if ((r_state == LOOKUP) && !r_we && cache_hit) begin
        r_rdata <= cache_rdata;
      end
      if ((r_state == MEM_RD) && mem_ack) begin
        r_refill <= mem_rdata;
      end
      if (r_state == REFILL) begin
        r_rdata <= r_refill;
      end
    end
  end

  assign cpu_rdata  = r_rdata;
  assign cpu_busy   = (r_state != IDLE);
  assign cache_addr = r_addr;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

  // Stores count against the cache too: a store hit updates, a store miss allocates.
  assign w_hit_inc  = (r_state == LOOKUP) &&  cache_hit;
  assign w_miss_inc = (r_state == LOOKUP) && !cache_hit;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit_inc),
    .clr   (perf_clr),
    .cnt   (hit_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_miss_inc),
    .clr   (perf_clr),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl with a behavioural cache/memory environment
// and a transaction-level reference model; counters built narrow to reach saturation.
module tb_dcache_ctrl;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_busy;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic          cache_we, cache_re, cache_hit;
  logic [DW-1:0] cache_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          perf_clr;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_re(cache_re), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .perf_clr(perf_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Environment: unbounded cache array and backing memory
  logic [DW-1:0] env_data  [0:4095];
  bit            env_valid [0:4095];
  logic [DW-1:0] env_mem   [0:4095];
  logic          flush_en = 1'b0;
  logic [AW-1:0] flush_addr = '0;

  assign cache_hit   = env_valid[cache_addr];
  assign cache_rdata = env_data[cache_addr];

  always @(posedge clk) begin
    if (cache_we) begin
      env_valid[cache_addr] <= 1'b1;
      env_data[cache_addr]  <= cache_wdata;
    end
    if (flush_en) env_valid[flush_addr] <= 1'b0;
  end

  // Reference model: what memory holds, which lines are resident, counters
  logic [DW-1:0] model_mem    [0:4095];
  bit            model_cached [0:4095];
  int            exp_hit, exp_miss;
  logic [DW-1:0] exp_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic flush(input logic [AW-1:0] a);
    @(negedge clk);
    flush_en   = 1'b1;
    flush_addr = a;
    model_cached[a] = 1'b0;
    @(negedge clk);
    flush_en = 1'b0;
  endtask

  // clr_mode: 0 none, 1 perf_clr in accept cycle, 2 perf_clr in LOOKUP cycle
  task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int n, input int clr_mode, input bit busy_req, input bit spur);
    bit hit;
    int exp_lat, cyc, mcnt;
    bit got;
    hit     = model_cached[a];
    exp_lat = we ? 2 + n : (hit ? 2 : 3 + n);
    if (clr_mode != 0) begin
      exp_hit  = 0;
      exp_miss = 0;
    end
    if (clr_mode != 2) begin
      if (hit) exp_hit = sat_inc(exp_hit);
      else     exp_miss = sat_inc(exp_miss);
    end

    @(negedge clk);
    chk("idle_busy", 64'(cpu_busy), 0);
    chk("idle_cache_en", 64'({cache_re, cache_we}), 0);
    chk("idle_mem_req", 64'(mem_req), 0);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    perf_clr  = (clr_mode == 1);
    mem_ack   = spur;
    mem_rdata = {$urandom, $urandom};

    cyc  = 0;
    mcnt = 0;
    got  = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ack  = 1'b0;
      perf_clr = (clr_mode == 2) && (cyc == 1);
      if (cyc == 1) begin
        chk("lookup_re", 64'(cache_re), 64'(!we));
        chk("lookup_we", 64'(cache_we), 64'(we));
        chk("lookup_addr", 64'(cache_addr), 64'(a));
        if (we) chk("lookup_wdata", cache_wdata, d);
        cpu_req = busy_req;
        if (busy_req) begin
          cpu_addr  = a ^ 12'h5A5;
          cpu_we    = ~we;
          cpu_wdata = ~d;
        end
        if (spur) begin
          mem_ack   = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end
      end
      if (mem_req) begin
        chk("mem_req_allowed", 64'(we || !hit), 1);
        chk("mem_addr", 64'(mem_addr), 64'(a));
        chk("mem_we", 64'(mem_we), 64'(we));
        if (we) chk("mem_wdata", mem_wdata, d);
        mcnt++;
        if (mcnt == n) begin
          mem_ack = 1'b1;
          if (we) env_mem[a] = mem_wdata;
          else    mem_rdata  = env_mem[a];
        end
      end
      if (!we && !hit && cyc == exp_lat - 1) begin
        chk("refill_we", 64'(cache_we), 1);
        chk("refill_data", cache_wdata, model_mem[a]);
      end
      if (cpu_ready) begin
        got = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_lat));
        if (!we) exp_rdata = model_mem[a];
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        cpu_req  = 1'b0;
        perf_clr = 1'b0;
      end
    end
    chk("complete", 64'(got), 1);
    cpu_req  = 1'b0;
    perf_clr = 1'b0;
    mem_ack  = 1'b0;
    if (we) model_mem[a] = d;
    model_cached[a] = 1'b1;
    @(negedge clk);
    chk("post_ready", 64'(cpu_ready), 0);
    chk("post_busy", 64'(cpu_busy), 0);
  endtask

  initial begin
    bit seen;
    int mseen;
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = {32'hC0DE0000 | 32'(i), 32'(i) * 32'h9E3779B9};
      env_mem[i]   = model_mem[i];
    end
    exp_hit   = 0;
    exp_miss  = 0;
    exp_rdata = '0;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    perf_clr  = 1'b0;
    #12;
    chk("rst_ready", 64'(cpu_ready), 0);
    chk("rst_busy", 64'(cpu_busy), 0);
    chk("rst_strobes", 64'({cache_we, cache_re, mem_req}), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_cnts", 64'({hit_cnt, miss_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load miss, reload hit, store write-through, load back
    env_mem[12'h123]   = 64'hDEAD_BEEF_0000_0001;
    model_mem[12'h123] = 64'hDEAD_BEEF_0000_0001;
    do_txn(1'b0, 12'h123, '0, 2, 0, 0, 0);
    do_txn(1'b0, 12'h123, '0, 1, 0, 0, 0);
    do_txn(1'b1, 12'h040, 64'h55AA, 3, 0, 0, 0);
    do_txn(1'b0, 12'h040, '0, 1, 0, 0, 0);

    // Busy request, spurious acks
    do_txn(1'b0, 12'h300, '0, 3, 0, 1, 1);
    do_txn(1'b1, 12'h308, 64'h1234_5678_9ABC_DEF0, 2, 0, 1, 1);

    // Saturate hit counter, then clear against a simultaneous hit
    for (int i = 0; i < 16; i++) do_txn(1'b0, 12'h123, '0, 1, 0, 0, 0);
    do_txn(1'b0, 12'h123, '0, 1, 2, 0, 0);
    do_txn(1'b0, 12'h040, '0, 1, 1, 0, 0);

    // Reset while waiting on a memory read
    flush(12'h200);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'h200;
    seen  = 1'b0;
    mseen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_req) mseen++;
      if (mseen == 2) seen = 1'b1;
    end
    chk("midrst_reached_mem_rd", 64'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 0);
    chk("midrst_busy", 64'(cpu_busy), 0);
    chk("midrst_ready", 64'(cpu_ready), 0);
    chk("midrst_cnts", 64'({hit_cnt, miss_cnt}), 0);
    chk("midrst_rdata", cpu_rdata, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_hit   = 0;
    exp_miss  = 0;
    exp_rdata = '0;
    do_txn(1'b0, 12'h200, '0, 2, 0, 0, 0);

    // Randomized traffic over a small address pool
    for (int t = 0; t < 250; t++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 31) << 3);
      if ($urandom_range(0, 5) == 0) flush(a);
      do_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
             int'($urandom_range(1, 4)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
